// File: rtl/seconds_counter.sv
// seconds_counter: prescaled 00-59 seconds counter with BCD digits.
//
// A prescaler divides clk by CLK_DIV while en is high; each terminal count
// (or a manual inc request) advances the two-digit seconds value. A load
// request presets both digits when the presented values are legal BCD seconds,
// otherwise it is rejected and flagged on loadErr.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   en         in   run enable for the prescaler
//   inc        in   manual advance request, honoured regardless of en
//   load       in   preset request for the digits
//   loadRight  in   [3:0] units digit to load (0-9)
//   loadLeft   in   [2:0] tens digit to load (0-5)
//   rightSecs  out  [3:0] registered units digit
//   leftSecs   out  [2:0] registered tens digit
//   secTick    out  one-cycle pulse after each prescaler terminal count
//   minuteTick out  one-cycle pulse coincident with the 59 -> 00 wrap
//   loadErr    out  one-cycle pulse after a rejected load

module seconds_counter #(
    parameter int unsigned CLK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       inc,
    input  logic       load,
    input  logic [3:0] loadRight,
    input  logic [2:0] loadLeft,
    output logic [3:0] rightSecs,
    output logic [2:0] leftSecs,
    output logic       secTick,
    output logic       minuteTick,
    output logic       loadErr
);

    localparam int unsigned PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    localparam logic [3:0] RIGHT_MAX = 4'd9;
    localparam logic [2:0] LEFT_MAX  = 3'd5;

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic [3:0]         right_d;
    logic [2:0]         left_d;
    logic               sec_tick_d;
    logic               minute_tick_d;
    logic               load_err_d;

    logic               load_valid;
    logic               load_take;
    logic               terminal;
    logic               advance;

    // Load is only accepted when both digits are within their legal ranges.
    assign load_valid = (loadRight <= RIGHT_MAX) && (loadLeft <= LEFT_MAX);
    assign load_take  = load && load_valid;

    // Terminal count only counts while the prescaler is running.
    assign terminal = en && (presc_q == PRESC_LAST);

    // Both advance sources merge into a single advance for the cycle.
    assign advance = terminal || inc;

    // Next-state computation; a taken load pre-empts counting and ticks.
    always_comb begin
        presc_d       = presc_q;
        right_d       = rightSecs;
        left_d        = leftSecs;
        sec_tick_d    = 1'b0;
        minute_tick_d = 1'b0;
        load_err_d    = 1'b0;

        if (load_take) begin
            right_d = loadRight;
            left_d  = loadLeft;
            presc_d = '0;
        end else begin
            if (en) begin
                presc_d = terminal ? '0 : presc_q + PRESC_W'(1);
            end
            sec_tick_d = terminal;
            // A rejected load still lets a coincident advance through.
            load_err_d = load;

            if (advance) begin
                // >= keeps the digits self-correcting into the legal range.
                if (rightSecs >= RIGHT_MAX) begin
                    right_d = 4'd0;
                    if (leftSecs >= LEFT_MAX) begin
                        left_d        = 3'd0;
                        minute_tick_d = 1'b1;
                    end else begin
                        left_d = leftSecs + 3'd1;
                    end
                end else begin
                    right_d = rightSecs + 4'd1;
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            rightSecs  <= 4'd0;
            leftSecs   <= 3'd0;
            secTick    <= 1'b0;
            minuteTick <= 1'b0;
            loadErr    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            rightSecs  <= right_d;
            leftSecs   <= left_d;
            secTick    <= sec_tick_d;
            minuteTick <= minute_tick_d;
            loadErr    <= load_err_d;
        end
    end

endmodule

// File: tb/tb_seconds_counter.sv
// Self-checking bench for seconds_counter (CLK_DIV = 4).
// A seconds-valued reference model (0..59 plus a prescaler phase) predicts
// every registered output; directed scenarios check against fixed values.

module tb_seconds_counter;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       inc;
    logic       load;
    logic [3:0] loadRight;
    logic [2:0] loadLeft;
    logic [3:0] rightSecs;
    logic [2:0] leftSecs;
    logic       secTick;
    logic       minuteTick;
    logic       loadErr;

    int checks = 0;
    int errors = 0;

    // Reference model state: whole seconds and prescaler phase.
    int m_secs  = 0;
    int m_phase = 0;
    bit m_sec_tick = 1'b0;
    bit m_min_tick = 1'b0;
    bit m_load_err = 1'b0;

    seconds_counter #(.CLK_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .inc        (inc),
        .load       (load),
        .loadRight  (loadRight),
        .loadLeft   (loadLeft),
        .rightSecs  (rightSecs),
        .leftSecs   (leftSecs),
        .secTick    (secTick),
        .minuteTick (minuteTick),
        .loadErr    (loadErr)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit r, input bit e, input bit i, input bit l,
                        input int lr, input int ll);
        bit tc;
        rst       = r;
        en        = e;
        inc       = i;
        load      = l;
        loadRight = 4'(lr);
        loadLeft  = 3'(ll);
        if (r) begin
            m_secs = 0; m_phase = 0;
            m_sec_tick = 0; m_min_tick = 0; m_load_err = 0;
        end else if (l && lr <= 9 && ll <= 5) begin
            m_secs = ll * 10 + lr; m_phase = 0;
            m_sec_tick = 0; m_min_tick = 0; m_load_err = 0;
        end else begin
            tc = e && (m_phase == int'(DIV) - 1);
            if (e) m_phase = (m_phase + 1) % int'(DIV);
            m_sec_tick = tc;
            m_load_err = l;
            m_min_tick = (tc || i) && (m_secs == 59);
            if (tc || i) m_secs = (m_secs + 1) % 60;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 1, 7, 3);
        step(1, 1, 1, 1, 2, 2);
        checks++; if (rightSecs !== 4'd0) begin errors++; $display("FAIL reset_right: got %0d expected 0", rightSecs); end
        checks++; if (leftSecs !== 3'd0) begin errors++; $display("FAIL reset_left: got %0d expected 0", leftSecs); end
        checks++; if (secTick !== 1'b0) begin errors++; $display("FAIL reset_sectick: got %b expected 0", secTick); end
        checks++; if (minuteTick !== 1'b0) begin errors++; $display("FAIL reset_minutetick: got %b expected 0", minuteTick); end
        checks++; if (loadErr !== 1'b0) begin errors++; $display("FAIL reset_loaderr: got %b expected 0", loadErr); end
    endtask

    task automatic test_count();
        bit exp_tick;
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 0, 0, 0, 0);
            exp_tick = ((k % 4) == 3);
            checks++; if (secTick !== exp_tick) begin errors++; $display("FAIL count_sectick[%0d]: got %b expected %b", k, secTick, exp_tick); end
            checks++; if (minuteTick !== 1'b0) begin errors++; $display("FAIL count_minutetick[%0d]: got %b expected 0", k, minuteTick); end
        end
        checks++; if (rightSecs !== 4'd3) begin errors++; $display("FAIL count_right: got %0d expected 3", rightSecs); end
        checks++; if (leftSecs !== 3'd0) begin errors++; $display("FAIL count_left: got %0d expected 0", leftSecs); end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        step(0, 1, 0, 1, 8, 5);
        checks++; if (rightSecs !== 4'd8 || leftSecs !== 3'd5) begin errors++; $display("FAIL wrap_load: got %0d/%0d expected 5/8", leftSecs, rightSecs); end
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 0, 0, 0, 0);
            if (minuteTick === 1'b1) pulses++;
            if (k == 3) begin
                checks++; if (rightSecs !== 4'd9 || leftSecs !== 3'd5) begin errors++; $display("FAIL wrap_59: got %0d/%0d expected 5/9", leftSecs, rightSecs); end
            end
            if (k == 7) begin
                checks++; if (rightSecs !== 4'd0 || leftSecs !== 3'd0) begin errors++; $display("FAIL wrap_00: got %0d/%0d expected 0/0", leftSecs, rightSecs); end
                checks++; if (minuteTick !== 1'b1) begin errors++; $display("FAIL wrap_minutetick: got %b expected 1", minuteTick); end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL wrap_pulse_count: got %0d expected 1", pulses); end
        step(0, 1, 0, 0, 0, 0);
        checks++; if (minuteTick !== 1'b0) begin errors++; $display("FAIL wrap_minutetick_drop: got %b expected 0", minuteTick); end
    endtask

    task automatic test_load_err();
        step(0, 0, 0, 1, 4, 1);
        checks++; if (rightSecs !== 4'd4 || leftSecs !== 3'd1 || loadErr !== 1'b0) begin errors++; $display("FAIL lerr_valid: got %0d/%0d err %b expected 1/4 err 0", leftSecs, rightSecs, loadErr); end
        step(0, 0, 0, 1, 10, 2);
        checks++; if (rightSecs !== 4'd4 || leftSecs !== 3'd1) begin errors++; $display("FAIL lerr_right10_digits: got %0d/%0d expected 1/4", leftSecs, rightSecs); end
        checks++; if (loadErr !== 1'b1) begin errors++; $display("FAIL lerr_right10_flag: got %b expected 1", loadErr); end
        step(0, 0, 0, 0, 0, 0);
        checks++; if (loadErr !== 1'b0) begin errors++; $display("FAIL lerr_flag_drop: got %b expected 0", loadErr); end
        step(0, 0, 0, 1, 3, 6);
        checks++; if (rightSecs !== 4'd4 || leftSecs !== 3'd1) begin errors++; $display("FAIL lerr_left6_digits: got %0d/%0d expected 1/4", leftSecs, rightSecs); end
        checks++; if (loadErr !== 1'b1) begin errors++; $display("FAIL lerr_left6_flag: got %b expected 1", loadErr); end
        // An invalid load must not swallow a coincident inc.
        step(0, 0, 1, 1, 15, 7);
        checks++; if (rightSecs !== 4'd5 || leftSecs !== 3'd1) begin errors++; $display("FAIL lerr_inc_digits: got %0d/%0d expected 1/5", leftSecs, rightSecs); end
        checks++; if (loadErr !== 1'b1) begin errors++; $display("FAIL lerr_inc_flag: got %b expected 1", loadErr); end
    endtask

    task automatic test_inc();
        step(0, 0, 0, 1, 8, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0, 0, 0);
            checks++; if (secTick !== 1'b0) begin errors++; $display("FAIL inc_sectick[%0d]: got %b expected 0", k, secTick); end
        end
        checks++; if (rightSecs !== 4'd1 || leftSecs !== 3'd1) begin errors++; $display("FAIL inc_digits: got %0d/%0d expected 1/1", leftSecs, rightSecs); end
        step(0, 0, 0, 1, 0, 2);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0);
        checks++; if (rightSecs !== 4'd0 || leftSecs !== 3'd2) begin errors++; $display("FAIL inc_pre_tc: got %0d/%0d expected 2/0", leftSecs, rightSecs); end
        step(0, 1, 1, 0, 0, 0);
        checks++; if (rightSecs !== 4'd1 || leftSecs !== 3'd2) begin errors++; $display("FAIL inc_coincident: got %0d/%0d expected 2/1", leftSecs, rightSecs); end
        checks++; if (secTick !== 1'b1) begin errors++; $display("FAIL inc_coincident_tick: got %b expected 1", secTick); end
    endtask

    task automatic test_load_priority();
        step(0, 1, 0, 1, 1, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 3);
        checks++; if (rightSecs !== 4'd0 || leftSecs !== 3'd3) begin errors++; $display("FAIL prio_digits: got %0d/%0d expected 3/0", leftSecs, rightSecs); end
        checks++; if (secTick !== 1'b0 || minuteTick !== 1'b0 || loadErr !== 1'b0) begin errors++; $display("FAIL prio_pulses: got sec %b min %b err %b expected 0 0 0", secTick, minuteTick, loadErr); end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, 0, 0, 0);
            checks++; if (secTick !== (k == 3)) begin errors++; $display("FAIL prio_phase[%0d]: got %b expected %b", k, secTick, (k == 3)); end
        end
        checks++; if (rightSecs !== 4'd1 || leftSecs !== 3'd3) begin errors++; $display("FAIL prio_after: got %0d/%0d expected 3/1", leftSecs, rightSecs); end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 1, 7, 4);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 5, 2);
        checks++; if (rightSecs !== 4'd0 || leftSecs !== 3'd0) begin errors++; $display("FAIL rmid_digits: got %0d/%0d expected 0/0", leftSecs, rightSecs); end
        checks++; if (secTick !== 1'b0 || minuteTick !== 1'b0 || loadErr !== 1'b0) begin errors++; $display("FAIL rmid_pulses: got sec %b min %b err %b expected 0 0 0", secTick, minuteTick, loadErr); end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, 0, 0, 0);
            checks++; if (secTick !== (k == 3)) begin errors++; $display("FAIL rmid_tick[%0d]: got %b expected %b", k, secTick, (k == 3)); end
        end
        checks++; if (rightSecs !== 4'd1 || leftSecs !== 3'd0) begin errors++; $display("FAIL rmid_after: got %0d/%0d expected 0/1", leftSecs, rightSecs); end
    endtask

    task automatic test_random();
        bit r, e, i, l;
        int lr, ll;
        step(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(63) == 0);
            e  = ($urandom_range(3) != 0);
            i  = ($urandom_range(3) == 0);
            l  = ($urandom_range(7) == 0);
            lr = int'($urandom_range(15));
            ll = int'($urandom_range(7));
            step(r, e, i, l, lr, ll);
            checks++; if (rightSecs !== 4'(m_secs % 10)) begin errors++; $display("FAIL rand_right[%0d]: got %0d expected %0d", n, rightSecs, m_secs % 10); end
            checks++; if (leftSecs !== 3'(m_secs / 10)) begin errors++; $display("FAIL rand_left[%0d]: got %0d expected %0d", n, leftSecs, m_secs / 10); end
            checks++; if (secTick !== m_sec_tick) begin errors++; $display("FAIL rand_sectick[%0d]: got %b expected %b", n, secTick, m_sec_tick); end
            checks++; if (minuteTick !== m_min_tick) begin errors++; $display("FAIL rand_minutetick[%0d]: got %b expected %b", n, minuteTick, m_min_tick); end
            checks++; if (loadErr !== m_load_err) begin errors++; $display("FAIL rand_loaderr[%0d]: got %b expected %b", n, loadErr, m_load_err); end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; inc = 1'b0; load = 1'b0;
        loadRight = 4'd0; loadLeft = 3'd0;
        test_reset();
        test_count();
        test_wrap();
        test_load_err();
        test_inc();
        test_load_priority();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
